// File: rtl/flit_reader.sv
// flit_reader: pops length-prefixed packets from a FWFT buffer and streams them
// through a 2-entry ready/valid output queue with sop/eop tagging.
module flit_reader #(
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_consume,
    input  logic                  enable,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic                  busy
);
    typedef enum logic {IDLE, BODY} state_t;
    state_t                 state, state_nx;
    logic [LEN_WIDTH-1:0]   rem, rem_nx;
    logic [1:0]             occ;
    logic [DATA_WIDTH-1:0]  q_data [2];
    logic [1:0]             q_sop, q_eop;
    logic                   in_sop, in_eop, pop, wr;
    always_comb begin
        fifo_consume = rst && !fifo_empty && !occ[1] && (state == BODY || enable);
        pop          = occ != 2'd0 && out_ready;
        in_sop       = state == IDLE;
        in_eop       = state == IDLE ? fifo_data[LEN_WIDTH-1:0] == '0 : rem == LEN_WIDTH'(1);
        state_nx     = state;
        rem_nx       = rem;
        if (fifo_consume) begin
            rem_nx   = state == IDLE ? fifo_data[LEN_WIDTH-1:0] : rem - LEN_WIDTH'(1);
            state_nx = in_eop ? IDLE : BODY;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            rem   <= '0;
        end else begin
            state <= state_nx;
            rem   <= rem_nx;
        end
    end
    // A push lands in the slot just behind whatever survives this cycle's pop.
    assign wr = occ[1] | (occ[0] & ~pop);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ       <= '0;
            q_data[0] <= '0;
            q_data[1] <= '0;
            q_sop     <= '0;
            q_eop     <= '0;
            pkt_count <= '0;
        end else begin
            occ <= occ + 2'(fifo_consume) - 2'(pop);
            if (pop) begin
                q_data[0] <= q_data[1];
                q_sop[0]  <= q_sop[1];
                q_eop[0]  <= q_eop[1];
            end
            if (fifo_consume) begin
                q_data[wr] <= fifo_data;
                q_sop[wr]  <= in_sop;
                q_eop[wr]  <= in_eop;
            end
            if (pop && q_eop[0])
                pkt_count <= pkt_count + CNT_WIDTH'(1);
        end
    end
    assign out_data  = q_data[0];
    assign out_sop   = q_sop[0];
    assign out_eop   = q_eop[0];
    assign out_valid = occ != 2'd0;
    assign busy      = state == BODY || occ != 2'd0;
endmodule

// File: tb/tb_flit_reader.sv
// tb_flit_reader: directed and random packet traffic checked against a packet-level
// model of the upstream buffer and the flits held between pop and accept.
module tb_flit_reader;
    localparam int CW = 4;
    logic          clk = 0, rst, fifo_empty, fifo_consume, enable, out_valid, out_ready;
    logic          out_sop, out_eop, busy;
    logic [63:0]   fifo_data, out_data;
    logic [CW-1:0] pkt_count;

    flit_reader #(.DATA_WIDTH(64), .LEN_WIDTH(4), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_consume(fifo_consume), .enable(enable), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop),
        .out_eop(out_eop), .pkt_count(pkt_count), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {logic [63:0] d; logic sop; logic eop;} flit_t;
    flit_t up[$];
    flit_t held[$];
    int    n_chk = 0, n_fail = 0, pkts = 0;
    bit    mid = 0, en = 1, rdy = 1, gap = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_pkt(input int len);
        flit_t f;
        f.d   = {$urandom, $urandom};
        f.d[3:0] = 4'(len);
        f.sop = 1;
        f.eop = len == 0;
        up.push_back(f);
        for (int i = 1; i <= len; i++) begin
            f.d   = {$urandom, $urandom};
            f.sop = 0;
            f.eop = i == len;
            up.push_back(f);
        end
    endtask

    task automatic step();
        bit    emp, c, a;
        flit_t f;
        emp        = up.size() == 0 || gap;
        fifo_empty = emp;
        fifo_data  = up.size() != 0 ? up[0].d : {$urandom, $urandom};
        enable     = en;
        out_ready  = rdy;
        #1;
        chk("consume", fifo_consume, !emp && held.size() < 2 && (mid || en));
        chk("valid", out_valid, held.size() != 0);
        chk("busy", busy, mid || held.size() != 0);
        chk("pkt_count", pkt_count, 64'(pkts % (1 << CW)));
        if (held.size() != 0) begin
            chk("data", out_data, held[0].d);
            chk("sop", out_sop, held[0].sop);
            chk("eop", out_eop, held[0].eop);
        end
        c = fifo_consume;
        a = out_valid && out_ready;
        @(posedge clk);
        if (a && held.size() != 0) begin
            f = held.pop_front();
            if (f.eop) pkts++;
        end
        if (c && up.size() != 0) begin
            f = up.pop_front();
            held.push_back(f);
            mid = !f.eop;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        gap = 0; rdy = 1; en = 1;
        for (int i = 0; i < 400 && (up.size() != 0 || held.size() != 0); i++) step();
        chk("drain_left", 64'(up.size() + held.size()), 0);
    endtask

    task automatic rand_phase(input int n);
        for (int i = 0; i < n; i++) begin
            if (up.size() < 4 && $urandom_range(0, 3) == 0) add_pkt(int'($urandom_range(0, 15)));
            en  = $urandom_range(0, 3) != 0;
            rdy = $urandom_range(0, 3) != 0;
            gap = $urandom_range(0, 4) == 0;
            step();
        end
    endtask

    initial begin
        rst = 0; fifo_empty = 0; fifo_data = '1; enable = 1; out_ready = 1;
        #12;
        chk("rst_consume", fifo_consume, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", out_data, 0);
        chk("rst_count", pkt_count, 0);
        @(negedge clk) rst = 1;
        add_pkt(2);
        repeat (5) step();
        add_pkt(0);
        repeat (3) step();
        rdy = 0;
        add_pkt(4);
        repeat (5) step();
        rdy = 1;
        repeat (8) step();
        add_pkt(3);
        add_pkt(1);
        step();
        en = 0;
        repeat (8) step();
        en = 1;
        repeat (6) step();
        rand_phase(600);
        drain();
        rdy = 0;
        add_pkt(5);
        repeat (4) step();
        chk("pre_rst_held", 64'(held.size()), 2);
        #2 rst = 0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sop", out_sop, 0);
        chk("mid_rst_count", pkt_count, 0);
        held.delete(); up.delete(); mid = 0; pkts = 0;
        @(negedge clk) rst = 1;
        rdy = 1;
        add_pkt(7);
        repeat (4) step();
        rand_phase(300);
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
